// File: rtl/downward_counter.sv
// Loadable down-counter with start/stop control, optional auto-reload and a
// registered one-cycle terminal-count pulse.
module downward_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic             en,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             running,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic             tc_q;
   logic             running_q;
   logic             done_q;

   // Strobes that would be no-ops in the current state do not block
   // lower-priority inputs on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         tc_q      <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         tc_q <= 1'b0;
         if (load) begin
            reload_q  <= load_value;
            count_q   <= load_value;
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
         end else if (stop && state_q == ST_RUN) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
         end else if (start && state_q != ST_RUN) begin
            if (state_q == ST_DONE) begin
               count_q <= reload_q;
            end
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
         end else if (state_q == ST_RUN && en) begin
            if (count_q != '0) begin
               count_q <= count_q - 1'b1;
            end else begin
               tc_q <= 1'b1;
               if (auto_reload) begin
                  count_q <= reload_q;
               end else begin
                  state_q   <= ST_DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
         end
      end
   end

   assign Q       = count_q;
   assign tc      = tc_q;
   assign running = running_q;
   assign done    = done_q;

endmodule

// File: doc/downward_counter.md
# downward_counter

Loadable, start/stop-controlled down-counter with an optional auto-reload mode and a registered terminal-count pulse. It counts qualified enable ticks down from a programmed reload value to zero. It is the decrementing complement of the team's up-counter and serves as the countdown timer and pulse-period generator in the counter library. Typical uses are gate windows, dead-time timers and divided-rate tick generation.

## Interface
- WIDTH, default 8, width of the count and reload value; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
- load  input  1  single-cycle strobe; loads load_value into both the reload register and Q.
- load_value  input  WIDTH  value captured on load.
- start  input  1  single-cycle strobe; begins or resumes counting.
- stop  input  1  single-cycle strobe; halts counting and holds Q.
- auto_reload  input  1  level; 1 = reload and continue at terminal count, 0 = one-shot.
- en  input  1  count-enable tick; Q advances only on clk edges where en = 1 while RUN.
- Q  output  WIDTH  current count.
- tc  output  1  terminal-count pulse, registered, high for exactly one clk cycle.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE; one-shot expiry indicator.

## Operation
- Internal state: reload register R (WIDTH bits) and a 3-state FSM: IDLE, RUN, DONE.
- Reset (reset = 0): Q = 0, R = 0, tc = 0, running = 0, done = 0, FSM = IDLE. These values hold for as long as reset is low.
- Priority per edge: load > stop > start > en.
- load (any state):
  - R ← load_value, Q ← load_value, FSM → IDLE.
  - Any same-cycle stop, start or en is ignored.
- stop:
  - RUN → IDLE with Q held.
  - In IDLE or DONE, stop is a no-op.
- start:
  - IDLE → RUN; Q is unchanged, so a stopped count resumes where it left off.
  - DONE → RUN with Q ← R.
  - In RUN, start is ignored.
- RUN with en = 1:
  - If Q > 0: Q ← Q − 1.
  - If Q = 0 (terminal count): tc is set for the next cycle.
    - auto_reload = 1: Q ← R, FSM stays RUN.
    - auto_reload = 0: Q stays 0, FSM → DONE.
- RUN with en = 0: everything holds.
- Period rule: one terminal count per R + 1 en ticks. With R = 0 and auto_reload = 1, tc fires on every en tick.
- Starting from IDLE with Q = 0 gives tc on the first en tick.
- auto_reload is sampled only on the terminal-count edge. It may change freely at other times.
- All arithmetic is unsigned WIDTH-bit. Q never underflows: 0 is never decremented.

## Timing
- Outputs are fully registered. There are no combinational paths from inputs to outputs.
- Q, running and done update on the same edge that samples the causing input, so they are visible one cycle after the strobe is applied.
- tc goes high on the edge where en is sampled at Q = 0. It is high for that following cycle only, then returns to 0 on the next edge regardless of inputs.
- Back-to-back tc is permitted (R = 0, en constantly 1, auto-reload): tc stays high continuously.
- tc is independent of later load or stop: a pulse already registered still completes its one cycle.
- Asynchronous reset mid-RUN forces all outputs to their reset values within the same cycle, without waiting for a clk edge. Counting resumes only after reset deasserts, followed by a load and/or start.
- Deassertion of reset is synchronized externally. The block samples no input on the edge where reset is low.

## Test plan
- One-shot: load 3, start, then en held at 1.
  - Q goes 3, 2, 1, 0.
  - tc is high for one cycle after the 4th en edge.
  - done = 1, running = 0, and Q stays 0 under further en.
- Auto-reload: load 2, auto_reload = 1, start, en held at 1 for 9 cycles.
  - Q goes 2, 1, 0, 2, 1, 0, 2, 1, 0.
  - tc pulses after en edges 3, 6 and 9.
  - running stays 1 throughout.
- Stop/resume with en gaps: load 5, start, en pulsed every other cycle.
  - stop when Q = 3: Q holds at 3 across 4 cycles of en.
  - start again: Q continues 2, 1, 0; tc fires once.
- Simultaneous strobes:
  - In RUN with Q = 4, assert load (value 7), stop and start together: Q = 7, IDLE, running = 0.
  - In DONE, start: Q ← 7, RUN.
- Asynchronous reset: in RUN with Q = 9, pull reset low between clk edges.
  - Q = 0, tc = running = done = 0 immediately.
  - After release, start with en = 1: first en gives tc, since Q = R = 0.
